uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//   UART serial transmitter; consumer of the debounced one-cycle "send" pulse
//   produced by the push-button stage. On an accepted send, latches a data byte
//   and shifts out start bit, data bits LSB-first, optional parity and stop bit(s)
//   on the tx pin. Drives busy/done back to the system; idle line is high.
// PARAMETERS
//   CLKS_PER_BIT  5208  clk cycles per serial bit (50 MHz / 9600 baud); legal >= 2
//   DATA_BITS     8     data bits per frame; legal 5..8
//   PARITY        0     0 = none, 1 = even, 2 = odd
//   STOP_BITS     1     stop bits per frame; legal 1 or 2
// PORTS
//   clk    in   1          system clock; all logic on posedge clk
//   rst    in   1          synchronous, active-high reset
//   send   in   1          request pulse (from send_button); sampled each edge
//   data   in   DATA_BITS  byte to transmit; sampled only on the accepting edge
//   tx     out  1          serial line, idle high
//   busy   out  1          high while a frame is in progress
//   done   out  1          one-cycle pulse at end of the final stop bit
// BEHAVIOUR
//   - Reset: tx=1, busy=0, done=0, state=IDLE, bit/baud counters=0. Reset
//     mid-frame aborts immediately (tx=1 at next edge), no done pulse.
//   - Registered outputs only; no combinational path from send/data to tx.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: tx=1, busy=0. Edge with send=1 and rst=0: latch data into shift reg,
//     go START; from next cycle tx=0, busy=1 (1-cycle latency send->start bit).
//   - send while busy=1 is ignored (not queued); data changes while busy ignored.
//   - Each bit held exactly CLKS_PER_BIT cycles; baud counter counts
//     0..CLKS_PER_BIT-1, bit advances on terminal count, counter wraps to 0.
//   - DATA: DATA_BITS bits, LSB first, shift reg shifts right per bit.
//   - PARITY (PARITY!=0 only): even = XOR of data bits; odd = inverted XOR.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Frame length F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles;
//     busy high exactly F cycles.
//   - On terminal count of last stop bit: state=IDLE, busy=0, done=1 for one
//     cycle (same edge busy falls). send sampled on that same edge is ignored;
//     earliest new accept is the following edge (back-to-back gap = 1 cycle of
//     idle high between frames).
//   - Counter widths sized by $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1).
// TESTING (CLKS_PER_BIT=4 unless noted)
//   1. rst=1 3 cycles with send=1 -> tx=1, busy=0, done=0 throughout; no frame.
//   2. data=8'hA5, send pulse, PARITY=0 -> tx: 0, 1,0,1,0,0,1,0,1, 1, each 4
//      cycles; start bit 1 cycle after send; busy high 40 cycles; done once.
//   3. PARITY=1 data=8'h07 -> parity bit 1; PARITY=2 same data -> parity bit 0;
//      busy high 44 cycles.
//   4. send pulses at cycles 5 and 20 of a frame with different data -> ignored;
//      transmitted bits match first latched byte; exactly one done.
//   5. send held high continuously -> frames back-to-back with one idle-high cycle
//      between; done pulses once per frame.
//   6. rst asserted during DATA bit 3 -> next edge tx=1, busy=0, no done; send
//      after rst release -> clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART serial transmitter fed by the one-cycle "send" pulse from the
//   push-button stage. An accepted send latches a data word, then shifts out a
//   start bit, the data bits LSB-first, an optional parity bit and one or two
//   stop bits on tx. The line idles high.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk    in   system clock, everything on posedge
//   rst    in   synchronous active-high reset
//   send   in   transmit request, accepted only while idle
//   data   in   word to transmit, sampled on the accepting edge only
//   tx     out  serial line (registered), idle high
//   busy   out  high for the whole frame (registered)
//   done   out  one-cycle pulse as the final stop bit ends (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_next;
  logic [BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_next, busy_next, done_next;
  logic                 baud_tick;

  // Last cycle of the current serial bit.
  assign baud_tick = (baud_cnt == BAUD_LAST);

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx         <= tx_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Next-state logic. tx is computed one cycle ahead so the pin is a flop
  // output; when a bit ends, tx_next already carries the following bit.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx;
    busy_next   = busy;
    done_next   = 1'b0;

    if (state != ST_IDLE) begin
      baud_next = baud_tick ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (send) begin
          state_next  = ST_START;
          baud_next   = '0;
          bit_next    = '0;
          shift_next  = data;
          // Parity is taken from the latched word, so later data changes
          // cannot affect it.
          parity_next = (PARITY == 2) ? ~^data : ^data;
          tx_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          state_next = ST_DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
            // shift_reg[1] is the bit that becomes the LSB after this shift.
            tx_next  = shift_reg[1];
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          state_next = ST_STOP;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          if (bit_cnt == STOP_LAST) begin
            // send on this edge is deliberately ignored; the earliest new
            // accept is the next edge, leaving one idle-high cycle.
            state_next = ST_IDLE;
            bit_next   = '0;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
        bit_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
